// File: rtl/exercise_decision_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exercise_decision_pkg
// Purpose  : Command codes, FSM state codes and fixed-point constants shared
//            by the exercise-decision stage.
// Revision : 1.0 - initial release
// ============================================================================
package exercise_decision_pkg;

    localparam int FRAC_BITS = 12;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_INIT   = 2'd0;
    localparam cmd_t CMD_EMIT   = 2'd1;
    localparam cmd_t CMD_DECIDE = 2'd2;
    localparam cmd_t CMD_AVG    = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_EMIT   = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_AVG    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/exercise_decision_cashflow_mem.sv
`default_nettype none
// ============================================================================
// Module   : exercise_decision_cashflow_mem
// Purpose  : One cashflow word per path; single write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
module exercise_decision_cashflow_mem #(
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int W      = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    // Deliberately not reset: contents are only meaningful after an INIT pass.
    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/exercise_decision.sv
`default_nettype none
// ============================================================================
// Module   : exercise_decision
// Purpose  : Longstaff-Schwartz backward-induction stage: per-path cashflow
//            store, discounted emit, early-exercise rewrite and final average.
// Revision : 1.0 - initial release
// ============================================================================
module exercise_decision
    import exercise_decision_pkg::*;
#(
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int W      = 12,
    parameter int DISC   = 4055
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic              in_valid,
    input  logic [W-1:0]      payoff,
    input  logic [W-1:0]      cont_value,
    output logic              busy,
    output logic              y_valid,
    output logic [W-1:0]      y_out,
    output logic [ADDR_W-1:0] y_idx,
    output logic [ADDR_W:0]   ex_count,
    output logic [W-1:0]      price,
    output logic              done
);

    localparam logic [W-1:0]      DISC_W   = W'(DISC);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);

    logic [2:0]          state_q,    state_d;
    cmd_t                cmd_q,      cmd_d;
    logic [ADDR_W-1:0]   idx_q,      idx_d;
    logic [ADDR_W+W-1:0] sum_q,      sum_d;
    logic [ADDR_W:0]     ex_cnt_q,   ex_cnt_d;
    logic [ADDR_W:0]     ex_count_q, ex_count_d;
    logic [W-1:0]        price_q,    price_d;
    logic                y_valid_q,  y_valid_d;
    logic [W-1:0]        y_out_q,    y_out_d;
    logic [ADDR_W-1:0]   y_idx_q,    y_idx_d;
    logic                done_q,     done_d;

    logic                mem_we;
    logic [W-1:0]        mem_wdata;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [ADDR_W-1:0]   mem_raddr;
    logic [W-1:0]        cf_rd;
    logic [W-1:0]        cf_disc;
    logic                exercise;
    logic                idx_last;

    // Paths are processed strictly in order, so read and write share idx.
    assign mem_waddr = idx_q;
    assign mem_raddr = idx_q;

    exercise_decision_cashflow_mem #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .W      (W)
    ) u_cashflow_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr  (mem_raddr),
        .rdata  (cf_rd)
    );

    // Full-width product, truncated (never rounded) back to W bits.
    assign cf_disc  = W'(({{W{1'b0}}, cf_rd} * {{W{1'b0}}, DISC_W}) >> FRAC_BITS);
    assign exercise = (payoff != '0) && (payoff > cont_value);
    assign idx_last = (idx_q == IDX_LAST);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        ex_cnt_d   = ex_cnt_q;
        ex_count_d = ex_count_q;
        price_d    = price_q;
        y_valid_d  = 1'b0;
        y_out_d    = y_out_q;
        y_idx_d    = y_idx_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = payoff;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd;
                    idx_d = '0;
                    case (cmd)
                        CMD_INIT:   state_d = ST_INIT;
                        CMD_EMIT:   state_d = ST_EMIT;
                        CMD_DECIDE: begin
                            state_d    = ST_DECIDE;
                            ex_cnt_d   = '0;
                            ex_count_d = '0;
                        end
                        default: begin
                            state_d = ST_AVG;
                            sum_d   = '0;
                        end
                    endcase
                end
            end
            ST_INIT: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + ADDR_W'(1);
                    if (idx_last) state_d = ST_DONE;
                end
            end
            ST_EMIT: begin
                y_valid_d = 1'b1;
                y_idx_d   = idx_q;
                y_out_d   = cf_disc;
                mem_we    = 1'b1;
                mem_wdata = cf_disc;
                idx_d     = idx_q + ADDR_W'(1);
                if (idx_last) state_d = ST_DONE;
            end
            ST_DECIDE: begin
                if (in_valid) begin
                    if (exercise) begin
                        mem_we   = 1'b1;
                        ex_cnt_d = ex_cnt_q + (ADDR_W+1)'(1);
                    end
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_last) state_d = ST_DONE;
                end
            end
            ST_AVG: begin
                sum_d = sum_q + {{ADDR_W{1'b0}}, cf_rd};
                idx_d = idx_q + ADDR_W'(1);
                if (idx_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (cmd_q == CMD_DECIDE) ex_count_d = ex_cnt_q;
                if (cmd_q == CMD_AVG)    price_d    = W'(sum_q >> ADDR_W);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_INIT;
            idx_q      <= '0;
            sum_q      <= '0;
            ex_cnt_q   <= '0;
            ex_count_q <= '0;
            price_q    <= '0;
            y_valid_q  <= 1'b0;
            y_out_q    <= '0;
            y_idx_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            ex_cnt_q   <= ex_cnt_d;
            ex_count_q <= ex_count_d;
            price_q    <= price_d;
            y_valid_q  <= y_valid_d;
            y_out_q    <= y_out_d;
            y_idx_q    <= y_idx_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign y_valid  = y_valid_q;
    assign y_out    = y_out_q;
    assign y_idx    = y_idx_q;
    assign ex_count = ex_count_q;
    assign price    = price_q;
    assign done     = done_q;

endmodule
`default_nettype wire
